// File: rtl/ram8.sv
// 8-word single-port RAM: combinational read, synchronous write, async active-high clear.
// Optional RAM8_INIT_ADDR_EN: reset loads word[i] = i instead of 0.
`timescale 1ns/1ps
module ram8 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic [2:0]       address,
  output logic [WIDTH-1:0] out
);

  localparam int unsigned DEPTH = 8;

  logic [WIDTH-1:0] word_q [DEPTH];
  logic [WIDTH-1:0] word_d [DEPTH];

  // Next-state: hold every word, overwrite only the addressed one when loading.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      word_d[i] = word_q[i];
    end
    if (load) begin
      word_d[address] = in;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
`ifdef RAM8_INIT_ADDR_EN
        word_q[i] <= WIDTH'(i);
`else
        word_q[i] <= '0;
`endif
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        word_q[i] <= word_d[i];
      end
    end
  end

  assign out = word_q[address];

endmodule

// File: tb/tb_ram8.sv
// Directed self-checking bench for ram8 using immediate assertions.
`timescale 1ns/1ps
module tb_ram8;

  logic        clk;
  logic        reset;
  logic [15:0] in;
  logic        load;
  logic [2:0]  address;
  logic [15:0] out;

  int n_checks = 0;
  int n_fails  = 0;

  ram8 #(.WIDTH(16)) dut (
    .clock   (clk),
    .reset   (reset),
    .in      (in),
    .load    (load),
    .address (address),
    .out     (out)
  );

  initial clk = 1'b0;
  always #1 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] rst_val(input int a);
`ifdef RAM8_INIT_ADDR_EN
    return 16'(a);
`else
    return (a >= 0) ? 16'h0000 : 16'h0001;
`endif
  endfunction

  task automatic compare(input string tag, input logic [15:0] exp);
    n_checks++;
    assert (out === exp) else begin
      n_fails++;
      $error("FAIL %s addr=%0d observed=%h expected=%h", tag, address, out, exp);
    end
  endtask

  task automatic check(input string tag, input int a, input logic [15:0] exp);
    @(negedge clk);
    address = 3'(a);
    #0.2;
    compare(tag, exp);
  endtask

  task automatic write(input int a, input logic [15:0] d);
    @(negedge clk);
    address = 3'(a);
    in      = d;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; in = '0; address = '0;
    #0.5;

    // Reset state at every address.
    for (int i = 0; i < 8; i++) check("reset_sweep", i, rst_val(i));

    // A write attempted while reset is held is ignored.
    @(negedge clk);
    address = 3'd3; in = 16'hFFFF; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("write_in_reset", 3, rst_val(3));

    // Single write.
    @(negedge clk);
    reset = 1'b0;
    write(4, 16'd15);
    for (int i = 0; i < 8; i++) check("single_write", i, (i == 4) ? 16'd15 : rst_val(i));

    // load low protects every word.
    @(negedge clk);
    in = 16'hFFFF; load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      address = 3'(i);
      repeat (4) @(posedge clk);
      check("load_low", i, (i == 4) ? 16'd15 : rst_val(i));
    end

    // Fill and readback.
    for (int i = 0; i < 8; i++) write(i, 16'hA000 + 16'(i));
    for (int i = 0; i < 8; i++) check("fill_read", i, 16'hA000 + 16'(i));

    // Overwrite word 7 only.
    write(7, 16'h1234);
    for (int i = 0; i < 8; i++) check("overwrite7", i, (i == 7) ? 16'h1234 : 16'hA000 + 16'(i));

    // Combinational read: address changes with no clock edge in between.
    @(negedge clk);
    address = 3'd2;
    #0.1;
    compare("comb_read_a2", 16'hA002);
    address = 3'd7;
    #0.1;
    compare("comb_read_a7", 16'h1234);
    address = 3'd0;
    #0.1;
    compare("comb_read_a0", 16'hA000);

    // Async reset between edges takes effect without a clock edge.
    address = 3'd7;
    #0.1;
    reset = 1'b1;
    #0.1;
    compare("async_reset_now", rst_val(7));
    @(negedge clk);
    address = 3'd5; in = 16'hBEEF; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("write_blocked_by_reset", 5, rst_val(5));
    for (int i = 0; i < 8; i++) check("reset_after_fill", i, rst_val(i));

    // Deassertion: writes work again from the next edge.
    @(negedge clk);
    reset = 1'b0;
    write(5, 16'hBEEF);
    check("write_after_release", 5, 16'hBEEF);
    check("neighbour_after_release", 6, rst_val(6));

    // Same address on consecutive edges: last value wins.
    @(negedge clk);
    address = 3'd1; in = 16'h1111; load = 1'b1;
    @(negedge clk);
    in = 16'h2222;
    @(negedge clk);
    load = 1'b0;
    #0.2;
    compare("last_value_wins", 16'h2222);
    check("last_value_neighbour", 0, rst_val(0));
    check("last_value_keep5", 5, 16'hBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
